axil_mem_arbiter: RTL and testbench
===================================

# axil_mem_arbiter

Two-requester arbiter and sequencer in front of the AXI4-Lite memory slave. It accepts simple single-beat read/write requests from two native requester ports and grants one at a time. It drives the winner's transaction onto a single AXI4-Lite master port and returns read data and response on a one-cycle acknowledge. It is the only master on the memory's AXI4-Lite slave port.

## Interface
- DW, 32: data width; WSTRB width is DW/8.
- AW, 8: requester address width (bits [7:6] block, [5:0] word); zero-extended to 32 on AXI.
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- REQ  in  2  per-requester request; bit n = requester n; held until ACK[n].
- WE  in  2  per-requester 1=write, 0=read; stable while REQ high.
- ADDR  in  2*AW  requester n at [n*AW +: AW].
- WDATA  in  2*DW  requester n at [n*DW +: DW].
- WSTRB  in  2*(DW/8)  requester n byte enables.
- ACK  out  2  one-cycle completion pulse to granted requester.
- RDATA  out  DW  read data, valid with ACK; shared by both requesters.
- RESP  out  2  BRESP/RRESP of completed transaction, valid with ACK.
- M_AXIL_AWADDR out 32, M_AXIL_AWVALID out 1, M_AXIL_AWREADY in 1: write address.
- M_AXIL_WDATA out DW, M_AXIL_WSTRB out DW/8, M_AXIL_WVALID out 1, M_AXIL_WREADY in 1: write data.
- M_AXIL_BRESP in 2, M_AXIL_BVALID in 1, M_AXIL_BREADY out 1: write response.
- M_AXIL_ARADDR out 32, M_AXIL_ARVALID out 1, M_AXIL_ARREADY in 1: read address.
- M_AXIL_RDATA in DW, M_AXIL_RRESP in 2, M_AXIL_RVALID in 1, M_AXIL_RREADY out 1: read data.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: if any REQ bit is high, pick the winner, latch its WE/ADDR/WDATA/WSTRB into registers, record grant index, go to WR_REQ if WE=1, else RD_REQ.
- Arbitration is round-robin. A one-bit pointer names the preferred requester. It wins if requesting, otherwise the other one wins. After each DONE the pointer moves to the requester not just served.
- WR_REQ: AWVALID and WVALID assert together. Each drops independently on its own handshake. When both handshakes have completed, including in the same cycle, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- RD_REQ: ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA and RRESP and go to DONE.
- DONE: ACK[grant]=1 for exactly one cycle. RDATA holds the captured value on writes too. Return to IDLE.
- Requests are never reordered or merged. Only one transaction is outstanding on AXI.
- Non-granted requester REQ may be high throughout. It waits, and is guaranteed service next under round-robin.
- Changes to REQ, WE or ADDR of the granted requester after latching are ignored.

## Timing
- Reset (async assert, sync release): state IDLE, pointer=0, ACK=0, RDATA=0, RESP=0. All M_AXIL VALID/READY=0, all M_AXIL address/data/strobe=0.
- REQ seen in IDLE at edge k: VALIDs high from cycle k+1.
- VALIDs drop the cycle after their handshake edge; never re-asserted within a transaction.
- ACK asserts the cycle after the B/R handshake edge.
- With a slave taking one cycle for AWREADY/WREADY and two more for BVALID: write REQ at k gives ACK at k+5. A read with ARREADY at k+2 and RVALID at k+3 gives ACK at k+4.
- Requester must drop REQ in the ACK cycle. REQ still high in the cycle after ACK is a new request.
- Minimum gap between back-to-back grants: one IDLE cycle.
- Reset mid-transaction aborts immediately. No ACK is issued and the requester must re-request.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins when both REQ bits are high, and the pointer is unused. Requester 1 can starve.
- Undefined (default): round-robin as described.

## Test plan
- Requester 0 writes ADDR=8'h45, WDATA=32'hDEADBEEF, WSTRB=4'hF, then reads 8'h45 -> ACK[0] each time; read RDATA=32'hDEADBEEF, RESP=2'b00.
- Partial write WSTRB=4'b0010, WDATA=32'h0000AB00 to 8'h81 (initial 32'h22222222), then read -> RDATA=32'h2222AB22.
- Both REQ high continuously, each issuing 4 reads -> grants alternate 0,1,0,1,... with ACK never on both bits in one cycle (round-robin build). Fixed-priority build: all four requester-0 ACKs precede requester 1.
- Slave delays AWREADY by 3 cycles but accepts W immediately -> WVALID drops after its handshake, AWVALID holds until accepted, exactly one B handshake, one ACK.
- ARESETN pulsed low while in WR_RESP -> all outputs zero within the same cycle, FSM IDLE, no ACK; a subsequent requester-1 read completes normally.
- Requester 1 read of 8'hC0 immediately after reset -> RDATA=32'h33333333, ACK[1] at k+4 with the single-cycle-ready slave.

Source files
------------

// File: rtl/axil_mem_arbiter.sv
// Two-requester round-robin arbiter that sequences single-beat requests onto one AXI4-Lite master port.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); the default build is round-robin.
module axil_mem_arbiter #(
   parameter int DW = 32,
   parameter int AW = 8
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [1:0]            REQ,
   input  logic [1:0]            WE,
   input  logic [2*AW-1:0]       ADDR,
   input  logic [2*DW-1:0]       WDATA,
   input  logic [2*(DW/8)-1:0]   WSTRB,
   output logic [1:0]            ACK,
   output logic [DW-1:0]         RDATA,
   output logic [1:0]            RESP,
   output logic [31:0]           M_AXIL_AWADDR,
   output logic                  M_AXIL_AWVALID,
   input  logic                  M_AXIL_AWREADY,
   output logic [DW-1:0]         M_AXIL_WDATA,
   output logic [DW/8-1:0]       M_AXIL_WSTRB,
   output logic                  M_AXIL_WVALID,
   input  logic                  M_AXIL_WREADY,
   input  logic [1:0]            M_AXIL_BRESP,
   input  logic                  M_AXIL_BVALID,
   output logic                  M_AXIL_BREADY,
   output logic [31:0]           M_AXIL_ARADDR,
   output logic                  M_AXIL_ARVALID,
   input  logic                  M_AXIL_ARREADY,
   input  logic [DW-1:0]         M_AXIL_RDATA,
   input  logic [1:0]            M_AXIL_RRESP,
   input  logic                  M_AXIL_RVALID,
   output logic                  M_AXIL_RREADY,
   output logic [2:0]            dbg_state
);

   localparam int SW = DW / 8;

   // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
   // VALID is never withdrawn before its handshake and never re-raised within a transaction.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic            grant_q, grant_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [1:0]      resp_q, resp_d;
   logic            win;
   logic            aw_hs;
   logic            w_hs;

`ifdef ARB_FIXED_PRIO_EN
   assign win = REQ[0] ? 1'b0 : 1'b1;
`else
   logic            ptr_q, ptr_d;
   // The preferred requester wins only if it is actually requesting.
   assign win = REQ[ptr_q] ? ptr_q : ~ptr_q;
`endif

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= ST_IDLE;
         grant_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      aw_done_d      = aw_done_q;
      w_done_d       = w_done_q;
      rdata_d        = rdata_q;
      resp_d         = resp_q;
`ifndef ARB_FIXED_PRIO_EN
      ptr_d          = ptr_q;
`endif
      aw_hs          = 1'b0;
      w_hs           = 1'b0;
      ACK            = 2'b00;
      M_AXIL_AWVALID = 1'b0;
      M_AXIL_WVALID  = 1'b0;
      M_AXIL_BREADY  = 1'b0;
      M_AXIL_ARVALID = 1'b0;
      M_AXIL_RREADY  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|REQ) begin
               grant_d   = win;
               addr_d    = win ? ADDR[AW +: AW]  : ADDR[0 +: AW];
               wdata_d   = win ? WDATA[DW +: DW] : WDATA[0 +: DW];
               wstrb_d   = win ? WSTRB[SW +: SW] : WSTRB[0 +: SW];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WE[win] ? ST_WR_REQ : ST_RD_REQ;
            end
         end
         ST_WR_REQ: begin
            // AW and W complete independently; leave once both have, even on the same edge.
            M_AXIL_AWVALID = !aw_done_q;
            M_AXIL_WVALID  = !w_done_q;
            aw_hs          = !aw_done_q && M_AXIL_AWREADY;
            w_hs           = !w_done_q && M_AXIL_WREADY;
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            M_AXIL_BREADY = 1'b1;
            if (M_AXIL_BVALID) begin
               resp_d  = M_AXIL_BRESP;
               state_d = ST_DONE;
            end
         end
         ST_RD_REQ: begin
            M_AXIL_ARVALID = 1'b1;
            if (M_AXIL_ARREADY) state_d = ST_RD_RESP;
         end
         ST_RD_RESP: begin
            M_AXIL_RREADY = 1'b1;
            if (M_AXIL_RVALID) begin
               rdata_d = M_AXIL_RDATA;
               resp_d  = M_AXIL_RRESP;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ACK[grant_q] = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            ptr_d        = ~grant_q;
`endif
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign M_AXIL_AWADDR = {{(32-AW){1'b0}}, addr_q};
   assign M_AXIL_ARADDR = {{(32-AW){1'b0}}, addr_q};
   assign M_AXIL_WDATA  = wdata_q;
   assign M_AXIL_WSTRB  = wstrb_q;
   assign RDATA         = rdata_q;
   assign RESP          = resp_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Directed bench for axil_mem_arbiter: two requester drivers, a behavioural AXI4-Lite memory slave
// with adjustable AWREADY delay, and inline per-scenario comparisons.
module tb_axil_mem_arbiter;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_RESP = 3'd2;

   logic         ACLK;
   logic         ARESETN;
   logic [1:0]   REQ, WE, ACK, RESP;
   logic [15:0]  ADDR;
   logic [63:0]  WDATA;
   logic [7:0]   WSTRB;
   logic [31:0]  RDATA;
   logic [31:0]  M_AXIL_AWADDR, M_AXIL_ARADDR, M_AXIL_WDATA, M_AXIL_RDATA;
   logic [3:0]   M_AXIL_WSTRB;
   logic         M_AXIL_AWVALID, M_AXIL_AWREADY, M_AXIL_WVALID, M_AXIL_WREADY;
   logic [1:0]   M_AXIL_BRESP, M_AXIL_RRESP;
   logic         M_AXIL_BVALID, M_AXIL_BREADY, M_AXIL_ARVALID, M_AXIL_ARREADY;
   logic         M_AXIL_RVALID, M_AXIL_RREADY;
   logic [2:0]   dbg_state;

   logic         req0, req1, we0, we1;
   logic [7:0]   addr0, addr1;
   logic [31:0]  wdata0, wdata1;
   logic [3:0]   wstrb0, wstrb1;

   assign REQ   = {req1, req0};
   assign WE    = {we1, we0};
   assign ADDR  = {addr1, addr0};
   assign WDATA = {wdata1, wdata0};
   assign WSTRB = {wstrb1, wstrb0};

   int checks = 0;
   int errors = 0;

   axil_mem_arbiter #(.DW(32), .AW(8)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA), .WSTRB(WSTRB),
      .ACK(ACK), .RDATA(RDATA), .RESP(RESP),
      .M_AXIL_AWADDR(M_AXIL_AWADDR), .M_AXIL_AWVALID(M_AXIL_AWVALID), .M_AXIL_AWREADY(M_AXIL_AWREADY),
      .M_AXIL_WDATA(M_AXIL_WDATA), .M_AXIL_WSTRB(M_AXIL_WSTRB), .M_AXIL_WVALID(M_AXIL_WVALID),
      .M_AXIL_WREADY(M_AXIL_WREADY),
      .M_AXIL_BRESP(M_AXIL_BRESP), .M_AXIL_BVALID(M_AXIL_BVALID), .M_AXIL_BREADY(M_AXIL_BREADY),
      .M_AXIL_ARADDR(M_AXIL_ARADDR), .M_AXIL_ARVALID(M_AXIL_ARVALID), .M_AXIL_ARREADY(M_AXIL_ARREADY),
      .M_AXIL_RDATA(M_AXIL_RDATA), .M_AXIL_RRESP(M_AXIL_RRESP), .M_AXIL_RVALID(M_AXIL_RVALID),
      .M_AXIL_RREADY(M_AXIL_RREADY),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- memory slave ----------------
   // Word-addressed by the low 8 address bits; block b (bits [7:6]) resets to 0xbbbbbbbb.
   logic [31:0] mem [256];
   int          aw_lat = 0;
   int          aw_cnt;
   logic        have_aw, have_w;
   logic [7:0]  aw_addr_s;
   logic [31:0] wdata_s, nw;
   logic [3:0]  wstrb_s;
   int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, vld_viol = 0, addr_hi_viol = 0, both_ack_n = 0;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h1111_1111 * 32'(i / 64);
         M_AXIL_AWREADY <= 1'b0;
         M_AXIL_WREADY  <= 1'b0;
         M_AXIL_BVALID  <= 1'b0;
         M_AXIL_BRESP   <= 2'b00;
         M_AXIL_ARREADY <= 1'b0;
         M_AXIL_RVALID  <= 1'b0;
         M_AXIL_RDATA   <= '0;
         M_AXIL_RRESP   <= 2'b00;
         have_aw        <= 1'b0;
         have_w         <= 1'b0;
         aw_cnt         <= 0;
         aw_addr_s      <= '0;
         wdata_s        <= '0;
         wstrb_s        <= '0;
      end else begin
         vld_viol <= vld_viol + int'(M_AXIL_AWVALID && have_aw) + int'(M_AXIL_WVALID && have_w);
         if ((M_AXIL_AWVALID && M_AXIL_AWADDR[31:8] != 24'd0) ||
             (M_AXIL_ARVALID && M_AXIL_ARADDR[31:8] != 24'd0))
            addr_hi_viol <= addr_hi_viol + 1;
         if (M_AXIL_AWVALID && M_AXIL_AWREADY) begin
            M_AXIL_AWREADY <= 1'b0;
            have_aw        <= 1'b1;
            aw_addr_s      <= M_AXIL_AWADDR[7:0];
            aw_cnt         <= 0;
            aw_hs_n        <= aw_hs_n + 1;
         end else if (M_AXIL_AWVALID && !have_aw && !M_AXIL_AWREADY) begin
            if (aw_cnt >= aw_lat) M_AXIL_AWREADY <= 1'b1;
            else aw_cnt <= aw_cnt + 1;
         end
         if (M_AXIL_WVALID && M_AXIL_WREADY) begin
            M_AXIL_WREADY <= 1'b0;
            have_w        <= 1'b1;
            wdata_s       <= M_AXIL_WDATA;
            wstrb_s       <= M_AXIL_WSTRB;
            w_hs_n        <= w_hs_n + 1;
         end else if (M_AXIL_WVALID && !have_w && !M_AXIL_WREADY) begin
            M_AXIL_WREADY <= 1'b1;
         end
         if (M_AXIL_BVALID && M_AXIL_BREADY) begin
            M_AXIL_BVALID <= 1'b0;
            have_aw       <= 1'b0;
            have_w        <= 1'b0;
            b_hs_n        <= b_hs_n + 1;
         end else if (have_aw && have_w && !M_AXIL_BVALID) begin
            nw = mem[aw_addr_s];
            for (int b = 0; b < 4; b++) if (wstrb_s[b]) nw[b*8 +: 8] = wdata_s[b*8 +: 8];
            mem[aw_addr_s] <= nw;
            M_AXIL_BVALID  <= 1'b1;
            M_AXIL_BRESP   <= 2'b00;
         end
         if (M_AXIL_RVALID && M_AXIL_RREADY) M_AXIL_RVALID <= 1'b0;
         if (M_AXIL_ARVALID && M_AXIL_ARREADY) begin
            M_AXIL_ARREADY <= 1'b0;
            M_AXIL_RVALID  <= 1'b1;
            M_AXIL_RDATA   <= mem[M_AXIL_ARADDR[7:0]];
            M_AXIL_RRESP   <= 2'b00;
         end else if (M_AXIL_ARVALID && !M_AXIL_ARREADY && !M_AXIL_RVALID) begin
            M_AXIL_ARREADY <= 1'b1;
         end
      end
   end

   always @(negedge ACLK) if (ACK == 2'b11) both_ack_n <= both_ack_n + 1;

   // ---------------- driver tasks ----------------
   task automatic set_req(input int n, input logic r, input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      if (n == 0) begin
         req0 = r; we0 = we; addr0 = a; wdata0 = d; wstrb0 = s;
      end else begin
         req1 = r; we1 = we; addr1 = a; wdata1 = d; wstrb1 = s;
      end
   endtask

   // Called at a negedge; lat counts edges from the first sampling edge up to the edge at which ACK is seen.
   task automatic do_req(input int n, input logic we, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat, output logic [31:0] rd, output logic [1:0] rs);
      logic got;
      got = 1'b0;
      lat = 0;
      rd  = '0;
      rs  = '0;
      set_req(n, 1'b1, we, a, d, s);
      while (!got && lat < 80) begin
         @(negedge ACLK);
         lat++;
         if (ACK[n]) begin
            got = 1'b1;
            rd  = RDATA;
            rs  = RESP;
         end
      end
      set_req(n, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      if (!got) lat = -1;
   endtask

   task automatic pulse_reset();
      ARESETN = 1'b0;
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [6:0] ctl;
      repeat (3) @(negedge ACLK);
      ctl = {ACK, RESP, M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_BREADY};
      checks++;
      if (ctl !== 7'd0 || M_AXIL_ARVALID !== 1'b0 || M_AXIL_RREADY !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: got ctl=%b arvalid=%b rready=%b want all 0", ctl, M_AXIL_ARVALID, M_AXIL_RREADY);
      end
      checks++;
      if ({RDATA, M_AXIL_AWADDR, M_AXIL_ARADDR, M_AXIL_WDATA, M_AXIL_WSTRB} !== 132'd0) begin
         errors++;
         $display("FAIL reset_data: rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h want 0",
                  RDATA, M_AXIL_AWADDR, M_AXIL_ARADDR, M_AXIL_WDATA, M_AXIL_WSTRB);
      end
      ARESETN = 1'b1;
      @(negedge ACLK);
      checks++;
      if (dbg_state !== S_IDLE || ACK !== 2'b00) begin
         errors++;
         $display("FAIL reset_release: state=%0d ack=%b want 0/00", dbg_state, ACK);
      end
   endtask

   task automatic test_read_after_reset();
      int lat; logic [31:0] rd; logic [1:0] rs;
      do_req(1, 1'b0, 8'hC0, 32'h0, 4'h0, lat, rd, rs);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL r1_read_latency: got %0d want 4", lat); end
      checks++;
      if (rd !== 32'h3333_3333 || rs !== 2'b00) begin
         errors++; $display("FAIL r1_read_data: got %h/%b want 33333333/00", rd, rs);
      end
      @(negedge ACLK);
      checks++;
      if (ACK !== 2'b00) begin errors++; $display("FAIL r1_ack_width: ack=%b want 00", ACK); end
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic [1:0] rs;
      do_req(0, 1'b1, 8'h45, 32'hDEAD_BEEF, 4'hF, lat, rd, rs);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL wr_latency: got %0d want 5", lat); end
      checks++;
      if (rs !== 2'b00 || rd !== 32'h3333_3333) begin
         errors++; $display("FAIL wr_ack_outputs: resp=%b rdata=%h want 00/33333333 (held)", rs, rd);
      end
      @(negedge ACLK);
      checks++;
      if (ACK !== 2'b00) begin errors++; $display("FAIL wr_ack_width: ack=%b want 00", ACK); end
      do_req(0, 1'b0, 8'h45, 32'h0, 4'h0, lat, rd, rs);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", lat); end
      checks++;
      if (rd !== 32'hDEAD_BEEF || rs !== 2'b00) begin
         errors++; $display("FAIL rd_data: got %h/%b want deadbeef/00", rd, rs);
      end
      @(negedge ACLK);
   endtask

   task automatic test_partial_write();
      int lat; logic [31:0] rd; logic [1:0] rs;
      do_req(0, 1'b1, 8'h81, 32'h0000_AB00, 4'b0010, lat, rd, rs);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL pw_latency: got %0d want 5", lat); end
      @(negedge ACLK);
      do_req(0, 1'b0, 8'h81, 32'h0, 4'h0, lat, rd, rs);
      checks++;
      if (rd !== 32'h2222_AB22) begin errors++; $display("FAIL pw_readback: got %h want 2222ab22", rd); end
      checks++;
      if (addr_hi_viol !== 0) begin errors++; $display("FAIL addr_zero_ext: got %0d want 0", addr_hi_viol); end
      @(negedge ACLK);
   endtask

   task automatic test_aw_delay();
      int lat; logic [31:0] rd; logic [1:0] rs;
      int aw0, w0, b0, v0;
      aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; v0 = vld_viol;
      aw_lat = 3;
      do_req(0, 1'b1, 8'h10, 32'h1234_5678, 4'hF, lat, rd, rs);
      @(negedge ACLK);
      aw_lat = 0;
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL awdly_latency: got %0d want 8", lat); end
      checks++;
      if (aw_hs_n - aw0 !== 1 || w_hs_n - w0 !== 1 || b_hs_n - b0 !== 1) begin
         errors++;
         $display("FAIL awdly_handshakes: aw=%0d w=%0d b=%0d want 1/1/1", aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0);
      end
      checks++;
      if (vld_viol - v0 !== 0) begin
         errors++; $display("FAIL awdly_valid_drop: got %0d valid-after-handshake cycles want 0", vld_viol - v0);
      end
      do_req(0, 1'b0, 8'h10, 32'h0, 4'h0, lat, rd, rs);
      checks++;
      if (rd !== 32'h1234_5678) begin errors++; $display("FAIL awdly_readback: got %h want 12345678", rd); end
      @(negedge ACLK);
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic [1:0] rs;
      int n;
      logic seen, ack_seen;
      set_req(0, 1'b1, 1'b1, 8'h20, 32'hCAFE_F00D, 4'hF);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 20) begin
         @(negedge ACLK);
         n++;
         if (dbg_state === S_WR_RESP) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL mid_reach_wr_resp: state=%0d want %0d", dbg_state, S_WR_RESP); end
      ARESETN = 1'b0;
      set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      #1;
      checks++;
      if ({ACK, RESP, M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_BREADY, M_AXIL_ARVALID, M_AXIL_RREADY} !== 9'd0 ||
          {RDATA, M_AXIL_AWADDR, M_AXIL_ARADDR, M_AXIL_WDATA, M_AXIL_WSTRB} !== 132'd0 || dbg_state !== S_IDLE) begin
         errors++;
         $display("FAIL mid_reset_outputs: state=%0d ack=%b bready=%b awaddr=%h wdata=%h want all 0",
                  dbg_state, ACK, M_AXIL_BREADY, M_AXIL_AWADDR, M_AXIL_WDATA);
      end
      ack_seen = 1'b0;
      repeat (3) begin
         @(negedge ACLK);
         if (ACK !== 2'b00) ack_seen = 1'b1;
      end
      ARESETN = 1'b1;
      repeat (3) begin
         @(negedge ACLK);
         if (ACK !== 2'b00) ack_seen = 1'b1;
      end
      checks++;
      if (ack_seen) begin errors++; $display("FAIL mid_no_ack: got an ACK want none"); end
      do_req(1, 1'b0, 8'hC1, 32'h0, 4'h0, lat, rd, rs);
      checks++;
      if (lat !== 4 || rd !== 32'h3333_3333) begin
         errors++; $display("FAIL mid_recover_read: lat=%0d rdata=%h want 4/33333333", lat, rd);
      end
      @(negedge ACLK);
   endtask

   task automatic test_round_robin();
      logic [0:0] exp_q[$];
      logic [0:0] got_q[$];
      logic [0:0] e, g;
      int both0;
      pulse_reset();
      both0 = both_ack_n;
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < 8; i++) exp_q.push_back(i < 4 ? 1'b0 : 1'b1);
`else
      for (int i = 0; i < 8; i++) exp_q.push_back(1'(i % 2));
`endif
      fork
         begin
            int lat; logic [31:0] rd; logic [1:0] rs;
            for (int i = 0; i < 4; i++) begin
               do_req(0, 1'b0, 8'(i), 32'h0, 4'h0, lat, rd, rs);
               if (lat > 0) got_q.push_back(1'b0);
               checks++;
               if (rd !== 32'h0000_0000) begin errors++; $display("FAIL rr_r0_data[%0d]: got %h want 00000000", i, rd); end
               @(negedge ACLK);
            end
         end
         begin
            int lat; logic [31:0] rd; logic [1:0] rs;
            for (int i = 0; i < 4; i++) begin
               do_req(1, 1'b0, 8'h40 + 8'(i), 32'h0, 4'h0, lat, rd, rs);
               if (lat > 0) got_q.push_back(1'b1);
               checks++;
               if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rr_r1_data[%0d]: got %h want 11111111", i, rd); end
               @(negedge ACLK);
            end
         end
      join
      checks++;
      if (got_q.size() !== 8) begin errors++; $display("FAIL rr_count: got %0d grants want 8", got_q.size()); end
      for (int i = 0; i < 8; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
         checks++;
         if (g !== e) begin errors++; $display("FAIL rr_order[%0d]: got requester %b want %b", i, g, e); end
      end
      checks++;
      if (both_ack_n - both0 !== 0) begin
         errors++; $display("FAIL rr_ack_exclusive: got %0d dual-ACK cycles want 0", both_ack_n - both0);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      ARESETN = 1'b0;
      set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      test_reset();
      test_read_after_reset();
      test_write_read();
      test_partial_write();
      test_aw_delay();
      test_reset_mid();
      test_round_robin();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
